// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack clock-domain crossing blocks:
// handshake state encoding and synchronizer depth limits.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        REQ_HI = 2'd2,
        REQ_LO = 2'd3
    } cdc_state_e;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Out-of-range depths are pulled back into the supported window.
    function automatic int clamp_sync_stages(input int n);
        if (n < SYNC_STAGES_MIN) begin
            return SYNC_STAGES_MIN;
        end
        if (n > SYNC_STAGES_MAX) begin
            return SYNC_STAGES_MAX;
        end
        return n;
    endfunction

endpackage

// File: rtl/cdc_sync_nff.sv
// Multi-flop reset-to-0 synchronizer for a single asynchronous bit,
// with a combinational bypass for scan/ATPG test mode.
module cdc_sync_nff
    import cdc_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic testmode_i,
    input  logic async_i,
    output logic sync_o
);

    localparam int DEPTH = clamp_sync_stages(STAGES);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], async_i};
        end
    end

    assign sync_o = testmode_i ? async_i : sync_q[DEPTH-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Launching end of a 4-phase req/ack crossing: holds one word and drives a registered req.
// Optional ack timeout enabled by defining CDC_TX_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | ready for a word; capture data on in_valid_i
// SETUP  | data_o settling for one cycle before req rises
// REQ_HI | req_o high, waiting for synchronized ack (or timeout)
// REQ_LO | req_o low, waiting for synchronized ack to drop; then done
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              testmode_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              req_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ack_i,
    output logic              done_o,
    output logic              err_o
);

    cdc_state_e        state_q;
    cdc_state_e        state_d;
    logic              req_d;
    logic [DATA_W-1:0] data_d;
    logic              done_d;
    logic              err_d;
    logic              ready_d;
    logic              ack_s;
    logic              timeout_hit;

    cdc_sync_nff #(
        .STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .testmode_i(testmode_i),
        .async_i   (ack_i),
        .sync_o    (ack_s)
    );

`ifdef CDC_TX_TIMEOUT_EN
    localparam int                CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // SETUP is the only way into REQ_HI, so clearing there restarts every wait.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if ((state_q == REQ_HI) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == REQ_HI) && (cnt_d == CNT_MAX);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_o;
        data_d  = data_o;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    data_d  = in_data_i;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                req_d   = 1'b1;
                state_d = REQ_HI;
            end
            REQ_HI: begin
                // A real ack wins over a timeout landing in the same cycle.
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REQ_LO;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // Every output is a flop so ack_i never reaches a port combinationally.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            req_o      <= 1'b0;
            data_o     <= '0;
            in_ready_o <= 1'b1;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_o      <= req_d;
            data_o     <= data_d;
            in_ready_o <= ready_d;
            done_o     <= done_d;
            err_o      <= err_d;
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with a cycle-based remote ack model.
module tb_cdc_handshake_tx;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 15;

    logic              clk_i = 1'b0;
    logic              reset_n_i;
    logic              testmode_i;
    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_ready_o;
    logic              req_o;
    logic [DATA_W-1:0] data_o;
    logic              ack_i;
    logic              done_o;
    logic              err_o;

    int total = 0;
    int bad   = 0;
    int remote_dly = 3;
    int remote_cnt = 0;

    cdc_handshake_tx #(
        .DATA_W     (DATA_W),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .testmode_i(testmode_i),
        .in_valid_i(in_valid_i),
        .in_data_i (in_data_i),
        .in_ready_o(in_ready_o),
        .req_o     (req_o),
        .data_o    (data_o),
        .ack_i     (ack_i),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Remote side: mirrors req onto ack remote_dly cycles after they differ.
    task automatic remote_step();
        if (req_o !== ack_i) begin
            remote_cnt++;
            if (remote_cnt == remote_dly) begin
                ack_i      = req_o;
                remote_cnt = 0;
            end
        end else begin
            remote_cnt = 0;
        end
    endtask

    task automatic accept(input logic [DATA_W-1:0] d);
        in_data_i  = d;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i  = 1'b0;
        testmode_i = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        ack_i      = 1'b0;
        #23;
        reset_n_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (req_o !== 1'b0 || in_ready_o !== 1'b1 || data_o !== 8'h00 ||
                done_o !== 1'b0 || err_o !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cyc %0d: got req=%b rdy=%b data=%h done=%b err=%b want 0 1 00 0 0",
                         i, req_o, in_ready_o, data_o, done_o, err_o);
            end
        end
    endtask

    task automatic test_single(input logic tm, input int exp_done_k);
        int done_k;
        int done_cnt;
        testmode_i = tm;
        remote_cnt = 0;
        done_k     = -1;
        done_cnt   = 0;
        accept(8'hA5);
        total++;
        if (data_o !== 8'hA5 || req_o !== 1'b0 || in_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL single_setup tm=%b: got data=%h req=%b rdy=%b want a5 0 0",
                     tm, data_o, req_o, in_ready_o);
        end
        tick();
        total++;
        if (req_o !== 1'b1) begin
            bad++;
            $display("FAIL single_req_rise tm=%b: got %b want 1", tm, req_o);
        end
        for (int k = 0; k < 25; k++) begin
            if (done_o === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            total++;
            if (data_o !== 8'hA5 || err_o !== 1'b0) begin
                bad++;
                $display("FAIL single_hold tm=%b k=%0d: got data=%h err=%b want a5 0",
                         tm, k, data_o, err_o);
            end
            remote_step();
            tick();
        end
        total++;
        if (done_k !== exp_done_k || done_cnt !== 1) begin
            bad++;
            $display("FAIL single_done tm=%b: got at=%0d count=%0d want at=%0d count=1",
                     tm, done_k, done_cnt, exp_done_k);
        end
        total++;
        if (in_ready_o !== 1'b1 || req_o !== 1'b0 || ack_i !== 1'b0) begin
            bad++;
            $display("FAIL single_end tm=%b: got rdy=%b req=%b ack=%b want 1 0 0",
                     tm, in_ready_o, req_o, ack_i);
        end
        testmode_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int first_done;
        int second_done;
        int done_cnt;
        testmode_i  = 1'b0;
        remote_cnt  = 0;
        first_done  = -1;
        second_done = -1;
        done_cnt    = 0;
        in_data_i   = 8'h11;
        in_valid_i  = 1'b1;
        tick();
        in_data_i   = 8'h22;
        for (int k = 0; k < 40; k++) begin
            if (done_o === 1'b1) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = k;
                    total++;
                    if (in_ready_o !== 1'b1 || data_o !== 8'h11) begin
                        bad++;
                        $display("FAIL b2b_first_done: got rdy=%b data=%h want 1 11",
                                 in_ready_o, data_o);
                    end
                end else if (second_done < 0) begin
                    second_done = k;
                end
            end else if (first_done < 0) begin
                total++;
                if (data_o !== 8'h11) begin
                    bad++;
                    $display("FAIL b2b_hold_11 k=%0d: got %h want 11", k, data_o);
                end
            end else if (k == first_done + 1) begin
                in_valid_i = 1'b0;
                total++;
                if (data_o !== 8'h22 || in_ready_o !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_accept_22: got data=%h rdy=%b want 22 0",
                             data_o, in_ready_o);
                end
            end else if (second_done < 0 && req_o === 1'b1) begin
                total++;
                if (data_o !== 8'h22) begin
                    bad++;
                    $display("FAIL b2b_hold_22 k=%0d: got %h want 22", k, data_o);
                end
            end
            remote_step();
            tick();
        end
        in_valid_i = 1'b0;
        total++;
        if (first_done !== 11 || second_done !== 23 || done_cnt !== 2) begin
            bad++;
            $display("FAIL b2b_done_times: got %0d %0d count=%0d want 11 23 count=2",
                     first_done, second_done, done_cnt);
        end
    endtask

    task automatic test_stale_ack();
        int done_k;
        done_k = -1;
        ack_i  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        accept(8'h3C);
        total++;
        if (req_o !== 1'b0 || data_o !== 8'h3C) begin
            bad++;
            $display("FAIL stale_setup: got req=%b data=%h want 0 3c", req_o, data_o);
        end
        tick();
        total++;
        if (req_o !== 1'b1) begin
            bad++;
            $display("FAIL stale_req_hi: got %b want 1", req_o);
        end
        tick();
        total++;
        if (req_o !== 1'b0) begin
            bad++;
            $display("FAIL stale_req_one_cycle: got %b want 0", req_o);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (req_o !== 1'b0 || done_o !== 1'b0 || in_ready_o !== 1'b0) begin
                bad++;
                $display("FAIL stale_wait_lo i=%0d: got req=%b done=%b rdy=%b want 0 0 0",
                         i, req_o, done_o, in_ready_o);
            end
        end
        ack_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (done_o === 1'b1 && done_k < 0) done_k = k;
        end
        total++;
        if (done_k !== 3 || in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL stale_done: got at=%0d rdy=%b want at=3 rdy=1", done_k, in_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        ack_i = 1'b0;
        accept(8'h5A);
        tick();
        total++;
        if (req_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_req_hi: got %b want 1", req_o);
        end
        #3;
        reset_n_i = 1'b0;
        #1;
        total++;
        if (req_o !== 1'b0 || in_ready_o !== 1'b1 || data_o !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_async: got req=%b rdy=%b data=%h want 0 1 00",
                     req_o, in_ready_o, data_o);
        end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (req_o !== 1'b0 || in_ready_o !== 1'b1 || done_o !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_idle i=%0d: got req=%b rdy=%b done=%b want 0 1 0",
                         i, req_o, in_ready_o, done_o);
            end
        end
    endtask

`ifdef CDC_TX_TIMEOUT_EN
    task automatic test_timeout();
        int err_k;
        int done_k;
        int err_cnt;
        err_k   = -1;
        done_k  = -1;
        err_cnt = 0;
        ack_i   = 1'b0;
        accept(8'hC3);
        tick();
        total++;
        if (req_o !== 1'b1) begin
            bad++;
            $display("FAIL tmo_req_rise: got %b want 1", req_o);
        end
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (err_o === 1'b1) begin
                err_cnt++;
                if (err_k < 0) begin
                    err_k = k;
                    total++;
                    if (req_o !== 1'b0) begin
                        bad++;
                        $display("FAIL tmo_req_fall: got %b want 0", req_o);
                    end
                end
            end
            if (done_o === 1'b1 && done_k < 0) done_k = k;
        end
        total++;
        if (err_k !== 15 || err_cnt !== 1 || done_k !== 16) begin
            bad++;
            $display("FAIL tmo_timing: got err_at=%0d errs=%0d done_at=%0d want 15 1 16",
                     err_k, err_cnt, done_k);
        end
    endtask
`else
    task automatic test_no_timeout();
        int fall_k;
        int done_k;
        fall_k = -1;
        done_k = -1;
        ack_i  = 1'b0;
        accept(8'hC3);
        tick();
        for (int i = 0; i < 40; i++) begin
            total++;
            if (req_o !== 1'b1 || err_o !== 1'b0) begin
                bad++;
                $display("FAIL notmo_wait i=%0d: got req=%b err=%b want 1 0", i, req_o, err_o);
            end
            tick();
        end
        ack_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (req_o === 1'b0 && fall_k < 0) fall_k = k;
        end
        ack_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (done_o === 1'b1 && done_k < 0) done_k = k;
        end
        total++;
        if (fall_k !== 3 || done_k !== 3 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL notmo_release: got fall_at=%0d done_at=%0d err=%b want 3 3 0",
                     fall_k, done_k, err_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single(1'b0, 10);
        test_back_to_back();
        test_stale_ack();
        test_reset_mid();
`ifdef CDC_TX_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_single(1'b1, 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
